// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run/step/halt sequencer emitting a paced one-cycle core clock-enable,
// with debounced board keys, a power-up core reset hold and a wrapping step counter.
module core_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned RST_HOLD     = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_run_n,
    input  logic             key_step_n,
    input  logic             key_halt_n,
    input  logic [2:0]       rate_sel,
    input  logic             halt_req,
    output logic             core_rst,
    output logic             core_ce,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] step_cnt
);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned BT_W  = $clog2(RST_HOLD + 1);
    localparam int unsigned DIV_W = 26;
    localparam int          KEY_RUN  = 0;
    localparam int          KEY_STEP = 1;
    localparam int          KEY_HALT = 2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        HALT = 2'd1,
        RUN  = 2'd2,
        STEP = 2'd3
    } state_e;

    logic [2:0]       key_s1_q, key_s2_q, key_lvl, deb_q, press_evt_q;
    logic [DB_W-1:0]  db_cnt_q [3];
    logic [2:0]       rate_s1_q, rate_s2_q, rate_last_q;
    logic             rate_chg;
    logic [DIV_W-1:0] div_max, div_q, div_d;
    logic [BT_W-1:0]  boot_cnt_q, boot_cnt_d;
    state_e           state_q, state_d;
    logic             ce_d, core_ce_q, core_rst_q;
    logic [CNT_W-1:0] step_cnt_q, cnt_d;
    logic             run_evt, step_evt, halt_evt, halt_any;

    // Key levels are held as "pressed" (active-high) once past the synchroniser.
    assign key_lvl = ~key_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q    <= 3'b111;
            key_s2_q    <= 3'b111;
            deb_q       <= '0;
            press_evt_q <= '0;
            for (int k = 0; k < 3; k++) db_cnt_q[k] <= '0;
        end else begin
            key_s1_q    <= {key_halt_n, key_step_n, key_run_n};
            key_s2_q    <= key_s1_q;
            press_evt_q <= '0;
            for (int k = 0; k < 3; k++) begin
                if (key_lvl[k] == deb_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    deb_q[k]       <= key_lvl[k];
                    db_cnt_q[k]    <= '0;
                    press_evt_q[k] <= key_lvl[k];
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_s1_q   <= '0;
            rate_s2_q   <= '0;
            rate_last_q <= '0;
        end else begin
            rate_s1_q   <= rate_sel;
            rate_s2_q   <= rate_s1_q;
            rate_last_q <= rate_s2_q;
        end
    end

    assign rate_chg = (rate_s2_q != rate_last_q);
    assign run_evt  = press_evt_q[KEY_RUN];
    assign step_evt = press_evt_q[KEY_STEP];
    assign halt_evt = press_evt_q[KEY_HALT];
    assign halt_any = halt_evt | halt_req;

    // Terminal divider value D-1 for the selected run rate.
    always_comb begin
        div_max = '0;
        case (rate_s2_q)
            3'd0:    div_max = DIV_W'(0);
            3'd1:    div_max = DIV_W'(1);
            3'd2:    div_max = DIV_W'(9);
            3'd3:    div_max = DIV_W'(99);
            3'd4:    div_max = DIV_W'(999);
            3'd5:    div_max = DIV_W'(9999);
            3'd6:    div_max = DIV_W'(999999);
            default: div_max = DIV_W'(49999999);
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
            div_q      <= '0;
            core_ce_q  <= 1'b0;
            core_rst_q <= 1'b1;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            div_q      <= div_d;
            core_ce_q  <= ce_d;
            core_rst_q <= (state_d == BOOT);
            step_cnt_q <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        div_d      = '0;
        case (state_q)
            BOOT: begin
                if (boot_cnt_q == BT_W'(RST_HOLD - 1)) state_d = HALT;
                else                                   boot_cnt_d = boot_cnt_q + BT_W'(1);
            end
            HALT: begin
                if (halt_evt)                  state_d = HALT;
                else if (step_evt)             state_d = STEP;
                else if (run_evt && !halt_req) state_d = RUN;
            end
            STEP: state_d = HALT;
            RUN: begin
                if (halt_any)                            state_d = HALT;
                else if (!rate_chg && div_q != div_max) div_d   = div_q + DIV_W'(1);
            end
            default: state_d = BOOT;
        endcase
    end

    // A step pulse is issued on entry to STEP so core_ce coincides with state STEP.
    always_comb begin
        ce_d = ((state_q == HALT) && (state_d == STEP)) ||
               ((state_q == RUN) && !halt_any && !rate_chg && (div_q == div_max));
        if (state_q == BOOT) cnt_d = '0;
        else                 cnt_d = step_cnt_q + CNT_W'(ce_d);
    end

    assign core_ce  = core_ce_q;
    assign core_rst = core_rst_q;
    assign state_o  = state_q;
    assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: self-checking bench for core_run_ctrl with short debounce/reset-hold
// and a 4-bit step counter so wrap-around is reachable.
module tb_core_run_ctrl;
    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_HALT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_STEP = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_run_n = 1'b1, key_step_n = 1'b1, key_halt_n = 1'b1;
    logic [2:0] rate_sel = 3'd0;
    logic       halt_req = 1'b0;
    logic       core_rst, core_ce;
    logic [1:0] state_o;
    logic [3:0] step_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt = 0;
    int div_tab [8] = '{1, 2, 10, 100, 1000, 10000, 1000000, 50000000};

    typedef struct {
        logic [2:0] rate;
        int         cycles;
        int         exp_pulses;
    } rate_vec_t;
    rate_vec_t vecs [4];

    core_run_ctrl #(.DEBOUNCE_CYC(4), .RST_HOLD(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_run_n  (key_run_n),
        .key_step_n (key_step_n),
        .key_halt_n (key_halt_n),
        .rate_sel   (rate_sel),
        .halt_req   (halt_req),
        .core_rst   (core_rst),
        .core_ce    (core_ce),
        .state_o    (state_o),
        .step_cnt   (step_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_key(input int which, input logic v);
        case (which)
            0:       key_run_n  = v;
            1:       key_step_n = v;
            default: key_halt_n = v;
        endcase
    endtask

    // Hold a key low then high, counting core_ce pulses and noting whether STEP was seen.
    task automatic key_seq(input int which, input int low_cyc, input int high_cyc,
                           output int n_ce, output bit saw_step);
        n_ce = 0;
        saw_step = 1'b0;
        set_key(which, 1'b0);
        for (int i = 0; i < low_cyc + high_cyc; i++) begin
            if (i == low_cyc) set_key(which, 1'b1);
            @(negedge clk);
            if (core_ce) n_ce++;
            if (state_o == S_STEP) saw_step = 1'b1;
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string name);
        int k = 0;
        while (state_o !== s && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(state_o), 32'(s));
    endtask

    task automatic set_rate(input logic [2:0] r);
        rate_sel = r;
        repeat (4) @(negedge clk);
    endtask

    // Returns at the first negedge where RUN is visible; divider is 0 at this point.
    task automatic enter_run(input string name);
        key_run_n = 1'b0;
        wait_state(S_RUN, 20, name);
    endtask

    task automatic wait_first_ce(input string name);
        int k = 0;
        while (!core_ce && k < 15) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(core_ce), 1);
    endtask

    // Raise halt_req before the next edge: that cycle must carry no pulse and land in HALT.
    task automatic stop_run(input string name);
        int extra = 0;
        halt_req = 1'b1;
        @(negedge clk);
        check({name, "_ce"}, 32'(core_ce), 0);
        check({name, "_state"}, 32'(state_o), 32'(S_HALT));
        halt_req  = 1'b0;
        key_run_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (core_ce) extra++;
        end
        check({name, "_quiet"}, extra, 0);
    endtask

    task automatic pulse_window(input int n, input int d, input bit per_cycle, output int pulses);
        pulses = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (core_ce) pulses++;
            if (per_cycle) check("rand_ce", 32'(core_ce), (i % d == 0) ? 1 : 0);
        end
    endtask

    initial begin
        int  n_ce, pulses, hi_cnt, d, n;
        bit  saw_step;

        vecs[0] = '{3'd0, 12, 12};
        vecs[1] = '{3'd1, 13, 6};
        vecs[2] = '{3'd2, 50, 5};
        vecs[3] = '{3'd3, 205, 2};

        // Reset: core_rst held 4 cycles after release, then HALT.
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state_o), 32'(S_BOOT));
        check("rst_core_rst", 32'(core_rst), 1);
        check("rst_ce", 32'(core_ce), 0);
        check("rst_cnt", 32'(step_cnt), 0);
        rst_n = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (core_rst) hi_cnt++;
            check("boot_state", 32'(state_o), (i < 4) ? 32'(S_BOOT) : 32'(S_HALT));
            check("boot_ce", 32'(core_ce), 0);
        end
        check("boot_rst_cycles", hi_cnt, 4);

        // Debounce: bouncing key gives nothing, a clean hold gives one step.
        n_ce = 0;
        for (int i = 0; i < 20; i++) begin
            key_step_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (core_ce) n_ce++;
        end
        check("bounce_no_ce", n_ce, 0);
        key_seq(1, 10, 12, n_ce, saw_step);
        exp_cnt++;
        check("step1_ce", n_ce, 1);
        check("step1_visit", 32'(saw_step), 1);
        check("step1_state", 32'(state_o), 32'(S_HALT));
        check("step1_cnt", 32'(step_cnt), exp_cnt % 16);
        key_seq(1, 12, 12, n_ce, saw_step);
        exp_cnt++;
        check("step2_ce", n_ce, 1);
        check("step2_cnt", 32'(step_cnt), exp_cnt % 16);

        // Run-rate table.
        foreach (vecs[v]) begin
            set_rate(vecs[v].rate);
            enter_run("tab_enter");
            pulse_window(vecs[v].cycles, 1, 1'b0, pulses);
            check("tab_pulses", pulses, vecs[v].exp_pulses);
            stop_run("tab_stop");
            exp_cnt += vecs[v].exp_pulses;
            check("tab_cnt", 32'(step_cnt), exp_cnt % 16);
        end

        // Rate change mid-run: one cleared cycle, then D=1 pacing.
        set_rate(3'd2);
        enter_run("rchg_enter");
        wait_first_ce("rchg_first");
        exp_cnt++;
        rate_sel = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rchg_gap", 32'(core_ce), 0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rchg_fast", 32'(core_ce), 1);
        end
        exp_cnt += 10;
        stop_run("rchg_stop");
        check("rchg_cnt", 32'(step_cnt), exp_cnt % 16);

        // Halt priority: halt_req on the divider's terminal cycle suppresses the pulse.
        set_rate(3'd2);
        enter_run("hp_enter");
        wait_first_ce("hp_first");
        exp_cnt++;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("hp_idle", 32'(core_ce), 0);
        end
        halt_req = 1'b1;
        @(negedge clk);
        check("hp_no_ce", 32'(core_ce), 0);
        check("hp_state", 32'(state_o), 32'(S_HALT));
        key_run_n = 1'b1;
        repeat (12) @(negedge clk);
        key_seq(0, 12, 12, n_ce, saw_step);
        check("hp_run_blocked_ce", n_ce, 0);
        check("hp_run_blocked_st", 32'(state_o), 32'(S_HALT));
        key_seq(1, 12, 12, n_ce, saw_step);
        exp_cnt++;
        check("hp_step_ce", n_ce, 1);
        check("hp_step_visit", 32'(saw_step), 1);
        halt_req = 1'b0;
        check("hp_cnt", 32'(step_cnt), exp_cnt % 16);

        // Halt key while running slowly.
        set_rate(3'd3);
        enter_run("hk_enter");
        key_run_n = 1'b1;
        key_seq(2, 12, 12, n_ce, saw_step);
        check("hk_ce", n_ce, 0);
        check("hk_state", 32'(state_o), 32'(S_HALT));
        check("hk_cnt", 32'(step_cnt), exp_cnt % 16);

        // Randomized runs against the rate-table model: pulse every D cycles from run entry.
        for (int it = 0; it < 8; it++) begin
            logic [2:0] r;
            r = 3'($urandom_range(0, 3));
            d = div_tab[r];
            n = $urandom_range(1, 3 * d + 5);
            set_rate(r);
            enter_run("rand_enter");
            pulse_window(n, d, 1'b1, pulses);
            stop_run("rand_stop");
            exp_cnt += n / d;
            check("rand_cnt", 32'(step_cnt), exp_cnt % 16);
        end

        // Wrap: fresh reset, 20 back-to-back pulses on a 4-bit counter.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_state(S_HALT, 10, "wrap_boot");
        exp_cnt = 0;
        check("wrap_cnt0", 32'(step_cnt), 0);
        set_rate(3'd0);
        enter_run("wrap_enter");
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            check("wrap_ce", 32'(core_ce), 1);
            check("wrap_cnt", 32'(step_cnt), i % 16);
        end
        stop_run("wrap_stop");
        exp_cnt = 20;
        check("wrap_final", 32'(step_cnt), exp_cnt % 16);

        // Asynchronous reset in the middle of a D=1 run.
        enter_run("mid_enter");
        repeat (3) @(negedge clk);
        check("mid_pre_ce", 32'(core_ce), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_ce", 32'(core_ce), 0);
        check("mid_core_rst", 32'(core_rst), 1);
        check("mid_cnt", 32'(step_cnt), 0);
        check("mid_state", 32'(state_o), 32'(S_BOOT));
        key_run_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
